// File: rtl/lsu_bus_master_if.sv
// CPU request/response channel plus the word-addressed, byte-enabled RAM bus
// driven by lsu_bus_master.
interface lsu_bus_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [29:0] bus_address;
  logic [31:0] bus_data_o;
  logic [31:0] bus_data_i;
  logic        bus_rd;
  logic        bus_wr;
  logic [3:0]  bus_byte_enable;

  modport master (
    input  req_valid, req_we, req_addr, req_size, req_signed, req_wdata, bus_data_i,
    output req_ready, resp_valid, resp_rdata, resp_err,
           bus_address, bus_data_o, bus_rd, bus_wr, bus_byte_enable
  );

  modport slave (
    output req_valid, req_we, req_addr, req_size, req_signed, req_wdata, bus_data_i,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           bus_address, bus_data_o, bus_rd, bus_wr, bus_byte_enable
  );
endinterface

// File: rtl/lsu_bus_master.sv
// Single-outstanding load/store initiator: byte request -> word bus access with
// lane enables, fixed strobe window, aligned and extended read return.
module lsu_bus_master #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  lsu_bus_master_if.master bus_io
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic [1:0]          off_q, off_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   bus_address_q, bus_address_d;
  logic [DATA_W-1:0]   bus_data_q, bus_data_d;
  logic                bus_rd_q, bus_rd_d;
  logic                bus_wr_q, bus_wr_d;
  logic [BE_W-1:0]     bus_be_q, bus_be_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;

  logic                req_bad_c;
  logic [BE_W-1:0]     req_be_c;
  logic [DATA_W-1:0]   req_wdata_c;
  logic [7:0]          ld_byte_c;
  logic [15:0]         ld_half_c;
  logic [DATA_W-1:0]   ld_data_c;

  // Request decode: alignment check, lane enables, replicated store word.
  always_comb begin
    req_bad_c   = 1'b0;
    req_be_c    = '0;
    req_wdata_c = bus_io.req_wdata;
    case (bus_io.req_size)
      2'b00: begin
        req_be_c    = BE_W'(1) << bus_io.req_addr[1:0];
        req_wdata_c = {4{bus_io.req_wdata[7:0]}};
      end
      2'b01: begin
        req_bad_c   = bus_io.req_addr[0];
        req_be_c    = bus_io.req_addr[1] ? 4'b1100 : 4'b0011;
        req_wdata_c = {2{bus_io.req_wdata[15:0]}};
      end
      2'b10: begin
        req_bad_c = (bus_io.req_addr[1:0] != 2'b00);
        req_be_c  = 4'b1111;
      end
      default: req_bad_c = 1'b1;
    endcase
  end

  // Load extraction: the muxes only ever select enabled lanes, so X/Z on idle lanes stays out.
  always_comb begin
    case (off_q)
      2'd0:    ld_byte_c = bus_io.bus_data_i[7:0];
      2'd1:    ld_byte_c = bus_io.bus_data_i[15:8];
      2'd2:    ld_byte_c = bus_io.bus_data_i[23:16];
      default: ld_byte_c = bus_io.bus_data_i[31:24];
    endcase
    ld_half_c = off_q[1] ? bus_io.bus_data_i[31:16] : bus_io.bus_data_i[15:0];
    case (size_q)
      2'b00:   ld_data_c = signed_q ? {{24{ld_byte_c[7]}}, ld_byte_c} : {24'd0, ld_byte_c};
      2'b01:   ld_data_c = signed_q ? {{16{ld_half_c[15]}}, ld_half_c} : {16'd0, ld_half_c};
      default: ld_data_c = bus_io.bus_data_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      size_q        <= '0;
      signed_q      <= 1'b0;
      off_q         <= '0;
      we_q          <= 1'b0;
      bus_address_q <= '0;
      bus_data_q    <= '0;
      bus_rd_q      <= 1'b0;
      bus_wr_q      <= 1'b0;
      bus_be_q      <= '0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      size_q        <= size_d;
      signed_q      <= signed_d;
      off_q         <= off_d;
      we_q          <= we_d;
      bus_address_q <= bus_address_d;
      bus_data_q    <= bus_data_d;
      bus_rd_q      <= bus_rd_d;
      bus_wr_q      <= bus_wr_d;
      bus_be_q      <= bus_be_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_err_q    <= resp_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    size_d        = size_q;
    signed_d      = signed_q;
    off_d         = off_q;
    we_d          = we_q;
    bus_address_d = bus_address_q;
    bus_data_d    = bus_data_q;
    bus_rd_d      = bus_rd_q;
    bus_wr_d      = bus_wr_q;
    bus_be_d      = bus_be_q;
    resp_valid_d  = 1'b0;
    resp_rdata_d  = resp_rdata_q;
    resp_err_d    = resp_err_q;
    case (state_q)
      IDLE: begin
        if (bus_io.req_valid) begin
          size_d   = bus_io.req_size;
          signed_d = bus_io.req_signed;
          off_d    = bus_io.req_addr[1:0];
          we_d     = bus_io.req_we;
          if (req_bad_c) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d       = ACCESS;
            bus_address_d = bus_io.req_addr[31:2];
            bus_be_d      = req_be_c;
            bus_data_d    = req_wdata_c;
            bus_rd_d      = ~bus_io.req_we;
            bus_wr_d      = bus_io.req_we;
            cnt_d         = CNT_W'(WAIT_CYCLES);
          end
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d      = RESP;
          bus_rd_d     = 1'b0;
          bus_wr_d     = 1'b0;
          bus_be_d     = '0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = we_q ? '0 : ld_data_c;
        end
      end
      RESP: begin
        state_d      = IDLE;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_io.req_ready       = (state_q == IDLE);
  assign bus_io.resp_valid      = resp_valid_q;
  assign bus_io.resp_rdata      = resp_rdata_q;
  assign bus_io.resp_err        = resp_err_q;
  assign bus_io.bus_address     = bus_address_q;
  assign bus_io.bus_data_o      = bus_data_q;
  assign bus_io.bus_rd          = bus_rd_q;
  assign bus_io.bus_wr          = bus_wr_q;
  assign bus_io.bus_byte_enable = bus_be_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed bench for lsu_bus_master: one zero-wait and one 3-wait instance,
// each attached to a small byte-lane RAM that floats disabled lanes.
module tb_lsu_bus_master;

  logic clk = 1'b0;
  logic rst0, rst3;
  always #5 clk = ~clk;

  lsu_bus_master_if if0();
  lsu_bus_master_if if3();

  lsu_bus_master #(.WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst0), .bus_io(if0));
  lsu_bus_master #(.WAIT_CYCLES(3)) dut3 (.clk(clk), .rst(rst3), .bus_io(if3));

  int checks = 0;
  int errors = 0;

  logic [31:0] mem0 [16];
  logic [31:0] mem3 [16];
  logic        pre_we, pre_sel;
  logic [3:0]  pre_idx;
  logic [31:0] pre_val;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] w;
    w = old;
    for (int k = 0; k < 4; k++) if (be[k]) w[8*k +: 8] = d[8*k +: 8];
    return w;
  endfunction

  // RAM models: disabled lanes read back as Z
  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign if0.bus_data_i[8*k +: 8] = if0.bus_byte_enable[k] ? mem0[if0.bus_address[3:0]][8*k +: 8] : 8'hzz;
    assign if3.bus_data_i[8*k +: 8] = if3.bus_byte_enable[k] ? mem3[if3.bus_address[3:0]][8*k +: 8] : 8'hzz;
  end

  always @(posedge clk) begin
    if (pre_we && !pre_sel) mem0[pre_idx] <= pre_val;
    else if (if0.bus_wr)
      mem0[if0.bus_address[3:0]] <= merge(mem0[if0.bus_address[3:0]], if0.bus_data_o, if0.bus_byte_enable);
  end

  always @(posedge clk) begin
    if (pre_we && pre_sel) mem3[pre_idx] <= pre_val;
    else if (if3.bus_wr)
      mem3[if3.bus_address[3:0]] <= merge(mem3[if3.bus_address[3:0]], if3.bus_data_o, if3.bus_byte_enable);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preset(input logic sel, input logic [3:0] idx, input logic [31:0] val);
    pre_sel = sel; pre_idx = idx; pre_val = val; pre_we = 1'b1;
    tick();
    pre_we = 1'b0;
  endtask

  // One complete transaction on the zero-wait instance with per-cycle checks
  task automatic access0(input string nm, input logic we, input logic [31:0] addr,
                         input logic [1:0] size, input logic sgn, input logic [31:0] wd,
                         input logic [3:0] exp_be, input logic [29:0] exp_addr,
                         input logic [31:0] exp_dout, input logic [31:0] exp_rd,
                         input logic exp_err);
    if0.req_valid = 1'b1; if0.req_we = we; if0.req_addr = addr;
    if0.req_size = size; if0.req_signed = sgn; if0.req_wdata = wd;
    checks++;
    if (if0.req_ready !== 1'b1) begin errors++; $display("FAIL %s ready: got %b want 1", nm, if0.req_ready); end
    tick();
    if0.req_valid = 1'b0;
    if (!exp_err) begin
      checks++;
      if ({if0.bus_rd, if0.bus_wr} !== {~we, we}) begin
        errors++; $display("FAIL %s strobes: got rd=%b wr=%b want rd=%b wr=%b", nm, if0.bus_rd, if0.bus_wr, ~we, we);
      end
      checks++;
      if (if0.bus_address !== exp_addr || if0.bus_byte_enable !== exp_be) begin
        errors++; $display("FAIL %s addr/be: got %h/%b want %h/%b", nm, if0.bus_address, if0.bus_byte_enable, exp_addr, exp_be);
      end
      if (we) begin
        checks++;
        if (if0.bus_data_o !== exp_dout) begin errors++; $display("FAIL %s wdata: got %h want %h", nm, if0.bus_data_o, exp_dout); end
      end
      checks++;
      if (if0.resp_valid !== 1'b0) begin errors++; $display("FAIL %s early resp: got %b want 0", nm, if0.resp_valid); end
      tick();
    end
    checks++;
    if ({if0.resp_valid, if0.resp_err} !== {1'b1, exp_err} || if0.resp_rdata !== exp_rd) begin
      errors++; $display("FAIL %s resp: got v=%b err=%b data=%h want v=1 err=%b data=%h",
                         nm, if0.resp_valid, if0.resp_err, if0.resp_rdata, exp_err, exp_rd);
    end
    checks++;
    if ({if0.bus_rd, if0.bus_wr, if0.bus_byte_enable} !== 6'b0) begin
      errors++; $display("FAIL %s strobes off: got rd=%b wr=%b be=%b want 0", nm, if0.bus_rd, if0.bus_wr, if0.bus_byte_enable);
    end
    tick();
    checks++;
    if ({if0.req_ready, if0.resp_valid} !== 2'b10) begin
      errors++; $display("FAIL %s after resp: got ready=%b v=%b want ready=1 v=0", nm, if0.req_ready, if0.resp_valid);
    end
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst3 = 1'b1; pre_we = 1'b0; pre_sel = 1'b0; pre_idx = '0; pre_val = '0;
    if0.req_valid = 1'b0; if0.req_we = 1'b0; if0.req_addr = '0; if0.req_size = '0; if0.req_signed = 1'b0; if0.req_wdata = '0;
    if3.req_valid = 1'b0; if3.req_we = 1'b0; if3.req_addr = '0; if3.req_size = '0; if3.req_signed = 1'b0; if3.req_wdata = '0;
    tick(); tick();
    checks++;
    if ({if0.bus_rd, if0.bus_wr, if0.bus_byte_enable, if0.resp_valid, if0.resp_err, if0.req_ready} !== 9'b000000001 ||
        if0.bus_address !== 30'd0 || if0.bus_data_o !== 32'd0 || if0.resp_rdata !== 32'd0) begin
      errors++; $display("FAIL reset0: got rd=%b wr=%b be=%b v=%b err=%b rdy=%b a=%h d=%h r=%h want all 0, rdy=1",
                         if0.bus_rd, if0.bus_wr, if0.bus_byte_enable, if0.resp_valid, if0.resp_err,
                         if0.req_ready, if0.bus_address, if0.bus_data_o, if0.resp_rdata);
    end
    checks++;
    if ({if3.bus_rd, if3.bus_wr, if3.bus_byte_enable, if3.resp_valid, if3.resp_err, if3.req_ready} !== 9'b000000001 ||
        if3.bus_address !== 30'd0 || if3.bus_data_o !== 32'd0 || if3.resp_rdata !== 32'd0) begin
      errors++; $display("FAIL reset3: got rd=%b wr=%b be=%b v=%b rdy=%b want 0s, rdy=1",
                         if3.bus_rd, if3.bus_wr, if3.bus_byte_enable, if3.resp_valid, if3.req_ready);
    end
    rst0 = 1'b0; rst3 = 1'b0;
    tick();
  endtask

  task automatic test_load_lanes();
    preset(1'b0, 4'd4, 32'hDEADBEEF);
    access0("ld_word",  1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 4'b1111, 30'd4, 32'h0, 32'hDEADBEEF, 1'b0);
    preset(1'b0, 4'd4, 32'h80FF0102);
    access0("ld_b_s13", 1'b0, 32'h13, 2'b00, 1'b1, 32'h0, 4'b1000, 30'd4, 32'h0, 32'hFFFFFF80, 1'b0);
    access0("ld_b_u13", 1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 4'b1000, 30'd4, 32'h0, 32'h00000080, 1'b0);
    access0("ld_b_s12", 1'b0, 32'h12, 2'b00, 1'b1, 32'h0, 4'b0100, 30'd4, 32'h0, 32'hFFFFFFFF, 1'b0);
    access0("ld_b_s11", 1'b0, 32'h11, 2'b00, 1'b1, 32'h0, 4'b0010, 30'd4, 32'h0, 32'h00000001, 1'b0);
    access0("ld_h_s12", 1'b0, 32'h12, 2'b01, 1'b1, 32'h0, 4'b1100, 30'd4, 32'h0, 32'hFFFF80FF, 1'b0);
    access0("ld_h_u10", 1'b0, 32'h10, 2'b01, 1'b0, 32'h0, 4'b0011, 30'd4, 32'h0, 32'h00000102, 1'b0);
    access0("ld_w_sgn", 1'b0, 32'h10, 2'b10, 1'b1, 32'h0, 4'b1111, 30'd4, 32'h0, 32'h80FF0102, 1'b0);
  endtask

  task automatic test_store();
    preset(1'b0, 4'd8, 32'h11223344);
    access0("st_h_22",  1'b1, 32'h22, 2'b01, 1'b0, 32'h0000ABCD, 4'b1100, 30'd8, 32'hABCDABCD, 32'h0, 1'b0);
    access0("rb_w_20",  1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 4'b1111, 30'd8, 32'h0, 32'hABCD3344, 1'b0);
    access0("st_b_21",  1'b1, 32'h21, 2'b00, 1'b0, 32'hFFFFFF5A, 4'b0010, 30'd8, 32'h5A5A5A5A, 32'h0, 1'b0);
    access0("rb_w_20b", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 4'b1111, 30'd8, 32'h0, 32'hABCD5A44, 1'b0);
    access0("st_w_24",  1'b1, 32'h24, 2'b10, 1'b0, 32'h01020304, 4'b1111, 30'd9, 32'h01020304, 32'h0, 1'b0);
    access0("rb_h_26",  1'b0, 32'h26, 2'b01, 1'b0, 32'h0, 4'b1100, 30'd9, 32'h0, 32'h00000102, 1'b0);
  endtask

  task automatic test_errors();
    access0("err_w_06", 1'b0, 32'h06, 2'b10, 1'b0, 32'h0, 4'b0, 30'd0, 32'h0, 32'h0, 1'b1);
    access0("err_sz11", 1'b0, 32'h00, 2'b11, 1'b0, 32'h0, 4'b0, 30'd0, 32'h0, 32'h0, 1'b1);
    access0("err_h_01", 1'b0, 32'h01, 2'b01, 1'b1, 32'h0, 4'b0, 30'd0, 32'h0, 32'h0, 1'b1);
    access0("err_sth",  1'b1, 32'h21, 2'b01, 1'b0, 32'hFFFFFFFF, 4'b0, 30'd0, 32'h0, 32'h0, 1'b1);
    access0("rb_noerr", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 4'b1111, 30'd8, 32'h0, 32'hABCD5A44, 1'b0);
  endtask

  // req_valid held high: load then store, each with a 4-cycle strobe window
  task automatic test_back_to_back();
    int ph;
    logic in_win;
    preset(1'b1, 4'd4, 32'hCAFEF00D);
    preset(1'b1, 4'd5, 32'h0);
    if3.req_valid = 1'b1; if3.req_we = 1'b0; if3.req_addr = 32'h10; if3.req_size = 2'b10;
    if3.req_signed = 1'b0; if3.req_wdata = 32'h0;
    for (int c = 0; c <= 12; c++) begin
      ph = c % 6;
      in_win = (ph >= 1) && (ph <= 4);
      checks++;
      if ({if3.bus_rd, if3.bus_wr, if3.resp_valid, if3.req_ready} !==
          {in_win && (c < 6), in_win && (c >= 6), ph == 5, ph == 0}) begin
        errors++; $display("FAIL b2b cycle %0d: got rd=%b wr=%b v=%b rdy=%b want rd=%b wr=%b v=%b rdy=%b",
                           c, if3.bus_rd, if3.bus_wr, if3.resp_valid, if3.req_ready,
                           in_win && (c < 6), in_win && (c >= 6), ph == 5, ph == 0);
      end
      if (c == 5 || c == 11) begin
        checks++;
        if (if3.resp_rdata !== ((c == 5) ? 32'hCAFEF00D : 32'h0) || if3.resp_err !== 1'b0) begin
          errors++; $display("FAIL b2b resp %0d: got %h err=%b want %h err=0", c, if3.resp_rdata, if3.resp_err,
                             (c == 5) ? 32'hCAFEF00D : 32'h0);
        end
      end
      if (c == 1) begin
        if3.req_we = 1'b1; if3.req_addr = 32'h14; if3.req_wdata = 32'h12345678;
      end
      if (c == 11) if3.req_valid = 1'b0;
      tick();
    end
    checks++;
    if (mem3[5] !== 32'h12345678) begin errors++; $display("FAIL b2b store: got %h want 12345678", mem3[5]); end
  endtask

  task automatic test_reset_abort();
    if3.req_valid = 1'b1; if3.req_we = 1'b0; if3.req_addr = 32'h10; if3.req_size = 2'b10;
    tick();
    if3.req_valid = 1'b0;
    tick();
    checks++;
    if (if3.bus_rd !== 1'b1) begin errors++; $display("FAIL abort pre: got rd=%b want 1", if3.bus_rd); end
    rst3 = 1'b1;
    tick();
    checks++;
    if ({if3.bus_rd, if3.bus_wr, if3.bus_byte_enable, if3.resp_valid} !== 7'b0 || if3.bus_address !== 30'd0) begin
      errors++; $display("FAIL abort reset: got rd=%b wr=%b be=%b v=%b a=%h want 0",
                         if3.bus_rd, if3.bus_wr, if3.bus_byte_enable, if3.resp_valid, if3.bus_address);
    end
    rst3 = 1'b0;
    tick();
    checks++;
    if (if3.req_ready !== 1'b1) begin errors++; $display("FAIL abort ready: got %b want 1", if3.req_ready); end
    for (int c = 0; c < 6; c++) begin
      checks++;
      if ({if3.resp_valid, if3.bus_rd} !== 2'b00) begin
        errors++; $display("FAIL abort quiet %0d: got v=%b rd=%b want 0", c, if3.resp_valid, if3.bus_rd);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_lanes();
    test_store();
    test_errors();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
